rrf_alloc_ctrl: RTL and testbench

//  Allocation/recovery controller for the rename register file and reorder buffer.

---
 rtl/rrf_alloc_ctrl.sv | 101 ++++++++++
 tb/tb_rrf_alloc_ctrl.sv | 226 ++++++++++++++++++++++
 2 files changed

// File: rtl/rrf_alloc_ctrl.sv
// rtl/rrf_alloc_ctrl.sv - ROB/RRF allocation controller: dispatch grants, commit returns, mispredict rollback
module rrf_alloc_ctrl #(
    parameter int RRF_NUM      = 64,
    parameter int RRF_SEL      = 6,
    parameter int RECOV_CYCLES = 2
) (
    input  logic               clk,
    input  logic               reset,
    input  logic [1:0]         req_num,
    input  logic [1:0]         comnum,
    input  logic [RRF_SEL-1:0] comptr,
    input  logic               prmiss,
    output logic               alloc_ok,
    output logic               dp1,
    output logic               dp2,
    output logic [RRF_SEL-1:0] dp1_addr,
    output logic [RRF_SEL-1:0] dp2_addr,
    output logic [RRF_SEL-1:0] dispatchptr,
    output logic [RRF_SEL:0]   rrf_freenum,
    output logic               stall_dp,
    output logic               ovf_err
);

    localparam int RCNT_W = (RECOV_CYCLES > 1) ? $clog2(RECOV_CYCLES) : 1;
    localparam logic [RRF_SEL:0]   FREE_MAX   = (RRF_SEL+1)'(RRF_NUM);
    localparam logic [RRF_SEL+1:0] FREE_MAX_W = (RRF_SEL+2)'(RRF_NUM);

    typedef enum logic {RUN, RECOVER} state_t;

    state_t             state, state_nxt;
    logic [RCNT_W-1:0]  rcnt, rcnt_nxt;
    logic [RRF_SEL-1:0] ptr_nxt;
    logic [RRF_SEL:0]   free_nxt;
    logic               ovf_nxt;
    logic [1:0]         n;
    logic [1:0]         alloc_cnt;
    logic [RRF_SEL+1:0] free_sum;

    // Grant is all-or-nothing and judged on the registered free count only
    assign n         = (req_num == 2'd3) ? 2'd2 : req_num;
    assign alloc_ok  = ~reset & (state == RUN) & ~prmiss
                       & (rrf_freenum >= {{(RRF_SEL-1){1'b0}}, n});
    assign dp1       = alloc_ok & (n != 2'd0);
    assign dp2       = alloc_ok & (n == 2'd2);
    assign stall_dp  = (n != 2'd0) & ~alloc_ok;
    assign dp1_addr  = dispatchptr;
    assign dp2_addr  = dispatchptr + RRF_SEL'(1);
    assign alloc_cnt = {1'b0, dp1} + {1'b0, dp2};

    // Two extra bits so that free + commit can be seen overshooting RRF_NUM
    assign free_sum  = {1'b0, rrf_freenum} - {RRF_SEL'(0), alloc_cnt}
                       + {RRF_SEL'(0), comnum};

    always_comb begin
        state_nxt = state;
        rcnt_nxt  = rcnt;
        ptr_nxt   = dispatchptr;
        free_nxt  = rrf_freenum;
        ovf_nxt   = ovf_err;
        if (prmiss) begin
            state_nxt = RECOVER;
            rcnt_nxt  = RCNT_W'(RECOV_CYCLES - 1);
            ptr_nxt   = comptr;
            free_nxt  = FREE_MAX;
        end else begin
            case (state)
                RUN: begin
                    ptr_nxt = dispatchptr + RRF_SEL'(alloc_cnt);
                    if (free_sum > FREE_MAX_W) begin
                        free_nxt = FREE_MAX;
                        ovf_nxt  = 1'b1;
                    end else begin
                        free_nxt = free_sum[RRF_SEL:0];
                    end
                end
                RECOVER: begin
                    if (rcnt == '0) state_nxt = RUN;
                    else            rcnt_nxt  = rcnt - RCNT_W'(1);
                end
                default: state_nxt = RUN;
            endcase
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state       <= RUN;
            rcnt        <= '0;
            dispatchptr <= '0;
            rrf_freenum <= FREE_MAX;
            ovf_err     <= 1'b0;
        end else begin
            state       <= state_nxt;
            rcnt        <= rcnt_nxt;
            dispatchptr <= ptr_nxt;
            rrf_freenum <= free_nxt;
            ovf_err     <= ovf_nxt;
        end
    end

endmodule

// File: tb/tb_rrf_alloc_ctrl.sv
// tb/tb_rrf_alloc_ctrl.sv - directed self-checking bench for rrf_alloc_ctrl
module tb_rrf_alloc_ctrl;

    logic       clk = 1'b0;
    logic       reset;
    logic [1:0] req_num;
    logic [1:0] comnum;
    logic [5:0] comptr;
    logic       prmiss;
    logic       alloc_ok, dp1, dp2, stall_dp, ovf_err;
    logic [5:0] dp1_addr, dp2_addr, dispatchptr;
    logic [6:0] rrf_freenum;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    rrf_alloc_ctrl #(.RRF_NUM(64), .RRF_SEL(6), .RECOV_CYCLES(2)) dut (
        .clk(clk), .reset(reset), .req_num(req_num), .comnum(comnum),
        .comptr(comptr), .prmiss(prmiss), .alloc_ok(alloc_ok), .dp1(dp1),
        .dp2(dp2), .dp1_addr(dp1_addr), .dp2_addr(dp2_addr),
        .dispatchptr(dispatchptr), .rrf_freenum(rrf_freenum),
        .stall_dp(stall_dp), .ovf_err(ovf_err)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic apply(input logic [1:0] r, input logic [1:0] c,
                         input logic [5:0] p, input logic m);
        req_num = r;
        comnum  = c;
        comptr  = p;
        prmiss  = m;
        #1;
    endtask

    initial begin
        #20000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        reset = 1'b0;
        req_num = 2'd0; comnum = 2'd0; comptr = 6'd0; prmiss = 1'b0;
        #2 reset = 1'b1;
        #1;
        chk("rst_ptr",      32'(dispatchptr), 0);
        chk("rst_free",     32'(rrf_freenum), 64);
        chk("rst_ovf",      32'(ovf_err), 0);
        chk("rst_alloc_ok", 32'(alloc_ok), 0);
        chk("rst_dp1",      32'(dp1), 0);
        chk("rst_dp2",      32'(dp2), 0);
        chk("rst_dp1_addr", 32'(dp1_addr), 0);
        chk("rst_dp2_addr", 32'(dp2_addr), 1);
        tick();
        reset = 1'b0;
        apply(2'd0, 2'd0, 6'd0, 1'b0);
        chk("run_idle_alloc_ok", 32'(alloc_ok), 1);
        chk("run_idle_stall",    32'(stall_dp), 0);

        // Position pointer at 9 via rollback, then fill 54 entries -> ptr 63, free 10
        apply(2'd2, 2'd0, 6'd9, 1'b1);
        chk("pm_setup_alloc_ok", 32'(alloc_ok), 0);
        tick();
        chk("pm_setup_ptr", 32'(dispatchptr), 9);
        apply(2'd0, 2'd0, 6'd9, 1'b0);
        tick();
        tick();
        for (int i = 0; i < 27; i++) begin
            apply(2'd2, 2'd0, 6'd9, 1'b0);
            tick();
        end
        chk("fill_ptr",  32'(dispatchptr), 63);
        chk("fill_free", 32'(rrf_freenum), 10);

        // Wrap
        apply(2'd2, 2'd0, 6'd9, 1'b0);
        chk("wrap_dp1_addr", 32'(dp1_addr), 63);
        chk("wrap_dp2_addr", 32'(dp2_addr), 0);
        chk("wrap_dp1",      32'(dp1), 1);
        chk("wrap_dp2",      32'(dp2), 1);
        tick();
        chk("wrap_ptr",  32'(dispatchptr), 1);
        chk("wrap_free", 32'(rrf_freenum), 8);

        // Drain to free=1 (ptr 8)
        for (int i = 0; i < 3; i++) begin
            apply(2'd2, 2'd0, 6'd9, 1'b0);
            tick();
        end
        apply(2'd1, 2'd0, 6'd9, 1'b0);
        tick();
        chk("b_free1", 32'(rrf_freenum), 1);
        apply(2'd2, 2'd0, 6'd9, 1'b0);
        chk("b_req2_alloc_ok", 32'(alloc_ok), 0);
        chk("b_req2_stall",    32'(stall_dp), 1);
        chk("b_req2_dp1",      32'(dp1), 0);
        tick();
        chk("b_req2_free_held", 32'(rrf_freenum), 1);
        chk("b_req2_ptr_held",  32'(dispatchptr), 8);
        apply(2'd1, 2'd0, 6'd9, 1'b0);
        chk("b_req1_alloc_ok", 32'(alloc_ok), 1);
        chk("b_req1_dp1",      32'(dp1), 1);
        chk("b_req1_dp2",      32'(dp2), 0);
        tick();
        chk("b_full_free", 32'(rrf_freenum), 0);
        chk("b_full_ptr",  32'(dispatchptr), 9);

        // Simultaneous request and commit
        apply(2'd1, 2'd2, 6'd9, 1'b0);
        chk("s_full_stall",    32'(stall_dp), 1);
        chk("s_full_alloc_ok", 32'(alloc_ok), 0);
        tick();
        chk("s_full_free", 32'(rrf_freenum), 2);
        apply(2'd0, 2'd2, 6'd9, 1'b0);
        tick();
        apply(2'd0, 2'd1, 6'd9, 1'b0);
        tick();
        chk("s_free5", 32'(rrf_freenum), 5);
        apply(2'd2, 2'd2, 6'd9, 1'b0);
        chk("s_both_alloc_ok", 32'(alloc_ok), 1);
        tick();
        chk("s_both_free", 32'(rrf_freenum), 5);
        chk("s_both_ptr",  32'(dispatchptr), 11);
        apply(2'd3, 2'd0, 6'd9, 1'b0);
        chk("s_req3_dp2", 32'(dp2), 1);
        tick();
        chk("s_req3_free", 32'(rrf_freenum), 3);
        chk("s_req3_ptr",  32'(dispatchptr), 13);

        // Recovery: get ptr to 40, then mispredict to comptr 17
        apply(2'd0, 2'd0, 6'd40, 1'b1);
        tick();
        apply(2'd0, 2'd0, 6'd40, 1'b0);
        tick();
        tick();
        chk("r_ptr40", 32'(dispatchptr), 40);
        apply(2'd2, 2'd0, 6'd17, 1'b1);
        chk("r_pm_alloc_ok", 32'(alloc_ok), 0);
        chk("r_pm_dp1",      32'(dp1), 0);
        tick();
        chk("r_ptr",  32'(dispatchptr), 17);
        chk("r_free", 32'(rrf_freenum), 64);
        apply(2'd2, 2'd2, 6'd17, 1'b0);
        chk("r_c1_stall", 32'(stall_dp), 1);
        tick();
        chk("r_c1_free", 32'(rrf_freenum), 64);
        chk("r_c1_ptr",  32'(dispatchptr), 17);
        apply(2'd2, 2'd0, 6'd17, 1'b0);
        chk("r_c2_stall", 32'(stall_dp), 1);
        tick();
        apply(2'd2, 2'd0, 6'd17, 1'b0);
        chk("r_c3_alloc_ok", 32'(alloc_ok), 1);
        chk("r_c3_stall",    32'(stall_dp), 0);
        tick();
        chk("r_c3_ptr",  32'(dispatchptr), 19);
        chk("r_c3_free", 32'(rrf_freenum), 62);

        // Second mispredict arriving inside RECOVER restarts the count
        apply(2'd0, 2'd0, 6'd5, 1'b1);
        tick();
        apply(2'd2, 2'd0, 6'd5, 1'b1);
        chk("x_pm2_stall", 32'(stall_dp), 1);
        tick();
        apply(2'd2, 2'd0, 6'd5, 1'b0);
        chk("x_c1_stall", 32'(stall_dp), 1);
        tick();
        apply(2'd2, 2'd0, 6'd5, 1'b0);
        chk("x_c2_stall", 32'(stall_dp), 1);
        tick();
        apply(2'd2, 2'd0, 6'd5, 1'b0);
        chk("x_c3_alloc_ok", 32'(alloc_ok), 1);
        tick();
        chk("x_ptr",  32'(dispatchptr), 7);
        chk("x_free", 32'(rrf_freenum), 62);

        // Overflow: 62 -> 63 -> saturate at 64 with sticky error
        apply(2'd0, 2'd1, 6'd5, 1'b0);
        tick();
        chk("o_free63", 32'(rrf_freenum), 63);
        chk("o_ovf_pre", 32'(ovf_err), 0);
        apply(2'd0, 2'd2, 6'd5, 1'b0);
        tick();
        chk("o_free_sat", 32'(rrf_freenum), 64);
        chk("o_ovf_set",  32'(ovf_err), 1);
        apply(2'd0, 2'd0, 6'd5, 1'b0);
        tick();
        tick();
        chk("o_ovf_sticky", 32'(ovf_err), 1);
        apply(2'd0, 2'd0, 6'd30, 1'b1);
        tick();
        apply(2'd1, 2'd0, 6'd30, 1'b0);
        chk("o_recover_stall", 32'(stall_dp), 1);
        chk("o_ovf_in_recover", 32'(ovf_err), 1);
        #2 reset = 1'b1;
        #1;
        chk("o_rst_ptr",  32'(dispatchptr), 0);
        chk("o_rst_free", 32'(rrf_freenum), 64);
        chk("o_rst_ovf",  32'(ovf_err), 0);
        tick();
        reset = 1'b0;
        apply(2'd1, 2'd0, 6'd0, 1'b0);
        chk("o_after_rst_alloc_ok", 32'(alloc_ok), 1);
        chk("o_after_rst_dp1_addr", 32'(dp1_addr), 0);
        tick();
        chk("o_after_rst_ptr",  32'(dispatchptr), 1);
        chk("o_after_rst_free", 32'(rrf_freenum), 63);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
